// File: rtl/arb_pack_pkg.sv
// Shared types and constants for the arbiter word packer: packed-word struct and keep-mask helper.
package arb_pack_pkg;

  localparam int unsigned BYTE_W                 = 8;
  localparam int unsigned DEF_BYTES_PER_WORD     = 4;
  localparam int unsigned DEF_OUT_DEPTH          = 4;
  localparam int unsigned DEF_FLUSH_TIMEOUT      = 16;
  localparam int unsigned WORD_W                 = BYTE_W * DEF_BYTES_PER_WORD;

  typedef struct packed {
    logic [WORD_W-1:0]             data;
    logic [DEF_BYTES_PER_WORD-1:0] keep;
  } packed_word_t;

  // Mask with the low `lanes` bits set, saturating at a full word.
  function automatic logic [DEF_BYTES_PER_WORD-1:0] keep_mask(input int unsigned lanes);
    logic [DEF_BYTES_PER_WORD-1:0] mask;
    mask = '0;
    for (int unsigned i = 0; i < DEF_BYTES_PER_WORD; i++) begin
      mask[i] = (i < lanes);
    end
    return mask;
  endfunction

endpackage

// File: rtl/arb_word_packer_if.sv
// Byte-in / word-out bundle of the arbiter word packer; slave modport is the packer side.
interface arb_word_packer_if
  import arb_pack_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD
);

  logic [BYTE_W-1:0]                din;
  logic                             din_valid;
  logic                             flush;
  logic [BYTE_W*BYTES_PER_WORD-1:0] word_out;
  logic [BYTES_PER_WORD-1:0]        word_keep;
  logic                             word_valid;
  logic                             word_ready;
  logic                             overflow;

  modport master (
    output din, din_valid, flush, word_ready,
    input  word_out, word_keep, word_valid, overflow
  );

  modport slave (
    input  din, din_valid, flush, word_ready,
    output word_out, word_keep, word_valid, overflow
  );

endinterface

// File: rtl/arb_pack_word_fifo.sv
// Synchronous FIFO of packed words. Push while full is accepted only if a pop happens on the
// same edge; pop while empty is ignored. Head reads as zero when empty.
module arb_pack_word_fifo
  import arb_pack_pkg::*;
#(
  parameter int unsigned Depth = DEF_OUT_DEPTH
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  packed_word_t wdata,
  input  logic         pop,
  output logic         full,
  output logic         empty,
  output packed_word_t head
);

  localparam int unsigned AddrW = $clog2(Depth);

  packed_word_t     mem_q [Depth];
  logic [AddrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AddrW:0]   count_q;
  logic             do_push, do_pop;

  always_comb begin
    empty   = (count_q == '0);
    full    = (count_q == (AddrW+1)'(Depth));
    do_pop  = pop & ~empty;
    do_push = push & (~full | do_pop);
    head    = empty ? '0 : mem_q[rd_ptr_q];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      if (do_push && !do_pop)      count_q <= count_q + 1'b1;
      else if (do_pop && !do_push) count_q <= count_q - 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible through head once counted.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/arb_word_packer.sv
// Packs the arbiter byte stream little-endian into words with a keep mask and buffers them.
// Optional idle auto-flush is built when ARB_PACK_TIMEOUT_FLUSH_EN is defined.
module arb_word_packer
  import arb_pack_pkg::*;
#(
  parameter int unsigned BYTES_PER_WORD = DEF_BYTES_PER_WORD,
  parameter int unsigned OUT_DEPTH      = DEF_OUT_DEPTH,
  parameter int unsigned FLUSH_TIMEOUT  = DEF_FLUSH_TIMEOUT
) (
  input logic               clk,
  input logic               rst,
  arb_word_packer_if.slave  bus
);

  localparam int unsigned WordW = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned LaneW = $clog2(BYTES_PER_WORD);

  logic [LaneW-1:0] lane_cnt_q, lane_cnt_d;
  logic [WordW-1:0] asm_q, asm_d, asm_merged;
  logic [LaneW:0]   lanes_filled;
  logic             overflow_q, overflow_d;
  logic             word_done, flush_req, push, pop;
  logic             timeout_flush;
  logic             fifo_full, fifo_empty;
  packed_word_t     push_word, head_word;

  always_comb begin
    asm_merged = asm_q;
    if (bus.din_valid) asm_merged[lane_cnt_q*BYTE_W +: BYTE_W] = bus.din;

    // Lanes occupied after this edge's byte, if any, is folded in.
    lanes_filled = {1'b0, lane_cnt_q} + (LaneW+1)'(bus.din_valid);
    word_done    = bus.din_valid && (lane_cnt_q == LaneW'(BYTES_PER_WORD - 1));
    flush_req    = bus.flush | timeout_flush;
    push         = word_done | (flush_req & (lanes_filled != '0));
    pop          = ~fifo_empty & bus.word_ready;

    push_word.data = asm_merged;
    push_word.keep = keep_mask(32'(lanes_filled));

    overflow_d = overflow_q | (push & fifo_full & ~pop);

    lane_cnt_d = lane_cnt_q;
    asm_d      = asm_q;
    if (push) begin
      // A dropped word still restarts assembly from lane 0.
      lane_cnt_d = '0;
      asm_d      = '0;
    end else if (bus.din_valid) begin
      lane_cnt_d = lane_cnt_q + 1'b1;
      asm_d      = asm_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lane_cnt_q <= '0;
      asm_q      <= '0;
      overflow_q <= 1'b0;
    end else begin
      lane_cnt_q <= lane_cnt_d;
      asm_q      <= asm_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef ARB_PACK_TIMEOUT_FLUSH_EN
  localparam int unsigned IdleW = $clog2(FLUSH_TIMEOUT + 1);

  logic [IdleW-1:0] idle_q, idle_d;

  always_comb begin
    // Fires on the FLUSH_TIMEOUT-th consecutive idle edge with a partial word held.
    timeout_flush = !bus.din_valid && (lane_cnt_q != '0) &&
                    (idle_q == IdleW'(FLUSH_TIMEOUT - 1));
    idle_d = '0;
    if (!bus.din_valid && !push && (lane_cnt_q != '0)) idle_d = idle_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) idle_q <= '0;
    else     idle_q <= idle_d;
  end
`else
  assign timeout_flush = 1'b0;
`endif

  arb_pack_word_fifo #(
    .Depth (OUT_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .wdata (push_word),
    .pop   (pop),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head_word)
  );

  assign bus.word_out   = head_word.data;
  assign bus.word_keep  = head_word.keep;
  assign bus.word_valid = ~fifo_empty;
  assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_arb_word_packer.sv
// Directed + random bench for arb_word_packer against a byte-queue / word-queue reference model.
module tb_arb_word_packer;
  import arb_pack_pkg::*;

  localparam int unsigned Bpw   = 4;
  localparam int unsigned Depth = 4;
  localparam int unsigned Tmo   = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  arb_word_packer_if #(.BYTES_PER_WORD(Bpw)) bus ();

  arb_word_packer #(
    .BYTES_PER_WORD (Bpw),
    .OUT_DEPTH      (Depth),
    .FLUSH_TIMEOUT  (Tmo)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: pending bytes, buffered words, sticky overflow, idle cycles.
  logic [7:0]  m_lanes[$];
  logic [31:0] m_data[$];
  logic [3:0]  m_keep[$];
  logic        m_ovf;
  int          m_idle;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_lanes.delete();
    m_data.delete();
    m_keep.delete();
    m_ovf  = 1'b0;
    m_idle = 0;
  endtask

  task automatic model_edge(input logic [7:0] d, input logic v, input logic f, input logic r);
    bit          pop, tflush, do_push;
    logic [31:0] w;
    int          kk;
    pop    = (m_data.size() > 0) && r;
    tflush = 1'b0;
`ifdef ARB_PACK_TIMEOUT_FLUSH_EN
    tflush = !v && (m_lanes.size() > 0) && (m_idle == Tmo - 1);
`endif
    if (v) m_lanes.push_back(d);
    do_push = (m_lanes.size() == Bpw) || ((f || tflush) && (m_lanes.size() > 0));
    if (pop) begin
      void'(m_data.pop_front());
      void'(m_keep.pop_front());
    end
    if (do_push) begin
      w = '0;
      foreach (m_lanes[i]) w[8*i +: 8] = m_lanes[i];
      kk = (1 << m_lanes.size()) - 1;
      if (m_data.size() < Depth) begin
        m_data.push_back(w);
        m_keep.push_back(kk[3:0]);
      end else begin
        m_ovf = 1'b1;
      end
      m_lanes.delete();
    end
    if (v || do_push)            m_idle = 0;
    else if (m_lanes.size() > 0) m_idle++;
    else                         m_idle = 0;
  endtask

  task automatic check_model(input string tag);
    bit ne;
    ne = m_data.size() > 0;
    chk({tag, ".valid"}, 32'(bus.word_valid), 32'(ne));
    chk({tag, ".data"},  bus.word_out, ne ? m_data[0] : 32'h0);
    chk({tag, ".keep"},  32'(bus.word_keep), ne ? 32'(m_keep[0]) : 32'h0);
    chk({tag, ".ovf"},   32'(bus.overflow), 32'(m_ovf));
  endtask

  task automatic step(input string tag, input logic [7:0] d, input logic v, input logic f,
                      input logic r);
    rst           = 1'b0;
    bus.din       = d;
    bus.din_valid = v;
    bus.flush     = f;
    bus.word_ready = r;
    @(posedge clk);
    model_edge(d, v, f, r);
    #1;
    check_model(tag);
  endtask

  task automatic reset_step(input string tag);
    rst           = 1'b1;
    bus.din       = 8'hA5;
    bus.din_valid = 1'b1;
    bus.flush     = 1'b1;
    bus.word_ready = 1'b1;
    @(posedge clk);
    model_reset();
    #1;
    check_model(tag);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    bus.din = '0; bus.din_valid = 1'b0; bus.flush = 1'b0; bus.word_ready = 1'b0;
    model_reset();

    reset_step("reset");
    chk("reset.valid_zero", 32'(bus.word_valid), 32'h0);
    chk("reset.word_zero", bus.word_out, 32'h0);

    // Full word, consumer ready.
    step("full0", 8'd87, 1'b1, 1'b0, 1'b1);
    step("full1", 8'd56, 1'b1, 1'b0, 1'b1);
    step("full2", 8'd9,  1'b1, 1'b0, 1'b1);
    chk("full.pre_valid", 32'(bus.word_valid), 32'h0);
    step("full3", 8'd13, 1'b1, 1'b0, 1'b1);
    chk("full.word", bus.word_out, 32'h0D093857);
    chk("full.keep", 32'(bus.word_keep), 32'hF);
    step("full.pop", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("full.one_cycle", 32'(bus.word_valid), 32'h0);

    // Partial flush, then an empty flush that must not push.
    step("pf0", 8'd85,  1'b1, 1'b0, 1'b0);
    step("pf1", 8'd139, 1'b1, 1'b0, 1'b0);
    step("pf.flush", 8'd0, 1'b0, 1'b1, 1'b0);
    chk("pf.word", bus.word_out, 32'h00008B55);
    chk("pf.keep", 32'(bus.word_keep), 32'h3);
    step("pf.flush2", 8'd0, 1'b0, 1'b1, 1'b0);
    step("pf.pop", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("pf.no_empty_word", 32'(bus.word_valid), 32'h0);

    // Flush together with a byte at lane 0.
    step("fb", 8'd51, 1'b1, 1'b1, 1'b0);
    chk("fb.word", bus.word_out, 32'h00000033);
    chk("fb.keep", 32'(bus.word_keep), 32'h1);
    step("fb.pop", 8'd0, 1'b0, 1'b0, 1'b1);

    // Overflow: five words into a four-deep FIFO with no consumer.
    for (int i = 0; i < 20; i++) step("ovf.fill", 8'(i + 1), 1'b1, 1'b0, 1'b0);
    chk("ovf.set", 32'(bus.overflow), 32'h1);
    chk("ovf.head", bus.word_out, 32'h04030201);
    for (int i = 0; i < 5; i++) step("ovf.drain", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("ovf.sticky", 32'(bus.overflow), 32'h1);
    chk("ovf.drained", 32'(bus.word_valid), 32'h0);

    // Full FIFO with a pop on the completing edge: push must be accepted.
    reset_step("fp.reset");
    for (int i = 0; i < 16; i++) step("fp.fill", 8'(8'h40 + i), 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) step("fp.part", 8'(8'h80 + i), 1'b1, 1'b0, 1'b0);
    step("fp.last", 8'h83, 1'b1, 1'b0, 1'b1);
    chk("fp.no_ovf", 32'(bus.overflow), 32'h0);
    for (int i = 0; i < 4; i++) step("fp.drain", 8'd0, 1'b0, 1'b0, 1'b1);
    chk("fp.count", 32'(bus.word_valid), 32'h0);

    // Reset mid-word discards stale lanes.
    step("rm0", 8'd1, 1'b1, 1'b0, 1'b0);
    step("rm1", 8'd2, 1'b1, 1'b0, 1'b0);
    reset_step("rm.reset");
    for (int i = 3; i <= 6; i++) step("rm.word", 8'(i), 1'b1, 1'b0, 1'b0);
    chk("rm.word_val", bus.word_out, 32'h06050403);
    step("rm.pop", 8'd0, 1'b0, 1'b0, 1'b1);

    // Idle timeout (only flushes in the macro build).
    step("to.byte", 8'd51, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < Tmo - 1; i++) step("to.idle", 8'd0, 1'b0, 1'b0, 1'b0);
    chk("to.early", 32'(bus.word_valid), 32'h0);
    step("to.edge", 8'd0, 1'b0, 1'b0, 1'b0);
`ifdef ARB_PACK_TIMEOUT_FLUSH_EN
    chk("to.word", bus.word_out, 32'h00000033);
    chk("to.keep", 32'(bus.word_keep), 32'h1);
`else
    chk("to.none", 32'(bus.word_valid), 32'h0);
`endif
    step("to.flush", 8'd0, 1'b0, 1'b1, 1'b1);
    step("to.drain", 8'd0, 1'b0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(99) == 0) begin
        reset_step("rnd.reset");
      end else begin
        step("rnd", 8'($urandom), ($urandom_range(99) < 70), ($urandom_range(99) < 6),
             ($urandom_range(99) < 45));
      end
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
